matmul_sequencer: RTL

MATMUL_SEQUENCER -- requirements
Module: matmul_sequencer

---
 rtl/matmul_sequencer.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/matmul_sequencer.sv
// Matrix-multiply sequencer: fetches one A row / B column pair per result element,
// reduces it LANES products per cycle and streams C out with saturation.
module matmul_sequencer #(
    parameter  int DIM    = 32,
    parameter  int DATA_W = 8,
    parameter  int LANES  = 4,
    parameter  int OUT_W  = 8,
    localparam int IDX_W  = ($clog2(DIM) > 1) ? $clog2(DIM) : 1
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  col_major,
    output logic [IDX_W-1:0]      req_row,
    output logic [IDX_W-1:0]      req_col,
    output logic                  req_valid,
    input  logic                  vec_valid,
    input  logic [DIM*DATA_W-1:0] row_vec,
    input  logic [DIM*DATA_W-1:0] col_vec,
    output logic [IDX_W-1:0]      row_out,
    output logic [IDX_W-1:0]      col_out,
    output logic [OUT_W-1:0]      elem_out,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  done
);

    localparam int GROUPS = DIM / LANES;
    localparam int GRP_W  = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam int ACC_W  = 2 * DATA_W + $clog2(DIM);
    localparam int CMP_W  = ((ACC_W > OUT_W) ? ACC_W : OUT_W) + 1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIM - 1);
    localparam logic [GRP_W-1:0] LAST_GRP = GRP_W'(GROUPS - 1);
    localparam logic [CMP_W-1:0] SAT_MAX  = (CMP_W'(1) << OUT_W) - CMP_W'(1);

    if (DIM < 2 || LANES < 1 || (DIM % LANES) != 0) begin : g_param_check
        $error("matmul_sequencer: DIM must be >= 2 and a multiple of LANES");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_MAC,
        S_OUT
    } state_t;

    state_t                state;
    logic                  start_q;
    logic                  col_major_q;
    logic [GRP_W-1:0]      grp;
    logic [ACC_W-1:0]      acc;
    logic [DIM*DATA_W-1:0] row_q;
    logic [DIM*DATA_W-1:0] col_q;

    logic                  start_edge;
    logic                  last_elem;
    logic [ACC_W-1:0]      lane_sum;
    logic [ACC_W-1:0]      acc_next;
    logic [CMP_W-1:0]      acc_wide;
    logic [OUT_W-1:0]      elem_sat;

    function automatic logic [ACC_W-1:0] widen(input logic [DATA_W-1:0] v);
        return ACC_W'(v);
    endfunction

    assign start_edge = start & ~start_q;
    assign last_elem  = (req_row == LAST_IDX) && (req_col == LAST_IDX);

    // NOTE: every variable assigned here gets a default first, so no path can
    // leave it holding an old value and infer a latch.
    always_comb begin
        lane_sum = '0;
        for (int l = 0; l < LANES; l++) begin
            lane_sum = lane_sum
                     + widen(row_q[(int'(grp) * LANES + l) * DATA_W +: DATA_W])
                     * widen(col_q[(int'(grp) * LANES + l) * DATA_W +: DATA_W]);
        end
        acc_next = acc + lane_sum;
        acc_wide = CMP_W'(acc_next);
        elem_sat = (acc_wide > SAT_MAX) ? SAT_MAX[OUT_W-1:0] : acc_wide[OUT_W-1:0];
    end

    // NOTE: operand vectors carry no reset; they are always written on
    // acceptance before the MAC phase reads them.
    always_ff @(posedge clk_in) begin
        if (!rst_in && !abort && state == S_REQ && vec_valid) begin
            row_q <= row_vec;
            col_q <= col_vec;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // branch below reads the values registered at the previous edge.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state       <= S_IDLE;
            start_q     <= 1'b0;
            col_major_q <= 1'b0;
            grp         <= '0;
            acc         <= '0;
            req_row     <= '0;
            req_col     <= '0;
            req_valid   <= 1'b0;
            row_out     <= '0;
            col_out     <= '0;
            elem_out    <= '0;
            out_valid   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            start_q <= start;
            if (abort && state != S_IDLE) begin
                state     <= S_IDLE;
                req_valid <= 1'b0;
                out_valid <= 1'b0;
                busy      <= 1'b0;
                done      <= 1'b0;
            end else begin
                unique case (state)
                    S_IDLE: begin
                        if (start_edge && !abort) begin
                            state       <= S_REQ;
                            col_major_q <= col_major;
                            req_row     <= '0;
                            req_col     <= '0;
                            req_valid   <= 1'b1;
                            busy        <= 1'b1;
                            done        <= 1'b0;
                        end
                    end
                    S_REQ: begin
                        if (vec_valid) begin
                            state     <= S_MAC;
                            req_valid <= 1'b0;
                            acc       <= '0;
                            grp       <= '0;
                        end
                    end
                    S_MAC: begin
                        acc <= acc_next;
                        grp <= grp + 1'b1;
                        if (grp == LAST_GRP) begin
                            state     <= S_OUT;
                            out_valid <= 1'b1;
                            elem_out  <= elem_sat;
                            row_out   <= req_row;
                            col_out   <= req_col;
                        end
                    end
                    S_OUT: begin
                        if (out_ready) begin
                            out_valid <= 1'b0;
                            if (last_elem) begin
                                state   <= S_IDLE;
                                busy    <= 1'b0;
                                done    <= 1'b1;
                                req_row <= '0;
                                req_col <= '0;
                            end else begin
                                state     <= S_REQ;
                                req_valid <= 1'b1;
                                // Column-major walks down a column before moving right.
                                if (col_major_q) begin
                                    if (req_row == LAST_IDX) begin
                                        req_row <= '0;
                                        req_col <= req_col + 1'b1;
                                    end else begin
                                        req_row <= req_row + 1'b1;
                                    end
                                end else begin
                                    if (req_col == LAST_IDX) begin
                                        req_col <= '0;
                                        req_row <= req_row + 1'b1;
                                    end else begin
                                        req_col <= req_col + 1'b1;
                                    end
                                end
                            end
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule
